xprog_loader: RTL and testbench

- DMA-side master for the program memory; it drives the memory's dma_sel/dma_we/dma_addr/dma_data_in port and consumes dma_data_out.
- Load mode: assembles a byte stream (e.g. from the host serial link) into DATA_W words and writes them to program memory.
- Dump mode: reads program memory words and serializes them as a byte stream for readback/verify.
- Sits beside the controller. It yields to the controller's data port, which has priority inside the memory.

---
 rtl/xprog_loader.sv | 208 ++++++++++++++++++++
 tb/tb_xprog_loader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xprog_loader.sv
// xprog_loader
//   DMA-side master for the program memory. It has two modes.
//   Load mode (mode=0): assembles an incoming byte stream, MSB first, into
//   DATA_W-bit words and writes each word to consecutive addresses.
//   Dump mode (mode=1): reads consecutive words and sends each one out as a
//   byte stream, MSB first.
//   A memory access is never issued while the controller holds its data port
//   (ctrl_sel=1). The access waits and is issued on the first free cycle.
//
// Ports
//   clk, rst_n          rising-edge clock; asynchronous active-low reset
//   start, mode         start pulse and transfer direction (0=load, 1=dump)
//   base_addr, word_cnt first word address and word count, sampled with start
//   in_data/in_valid/in_ready     load byte stream (valid/ready handshake)
//   out_data/out_valid/out_ready  dump byte stream (valid/ready handshake)
//   ctrl_sel            controller owns the memory data port while high
//   dma_sel/dma_we/dma_addr/dma_wdata/dma_rdata  memory DMA port
//                       (read data arrives one cycle after the read is issued)
//   busy, done          transfer in progress; one-cycle end-of-transfer pulse
//   checksum            mod-256 sum of every byte moved by the last transfer
module xprog_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              ctrl_sel,
  output logic              dma_sel,
  output logic              dma_we,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_wdata,
  input  logic [DATA_W-1:0] dma_rdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum
);

  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_BYTE,
    S_LD_WR,
    S_RD_ISSUE,
    S_RD_CAP,
    S_TX,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   remain_reg;
  logic [DATA_W-1:0] word_reg;
  logic [BC_W-1:0]   byte_cnt_reg;
  logic [7:0]        checksum_reg;

  // Datapath strobes produced by the FSM.
  logic take_start;
  logic byte_in;
  logic byte_out;
  logic capture;
  logic word_step;
  logic last_byte;
  logic last_word;

  assign last_byte = (byte_cnt_reg == BC_W'(BYTES - 1));
  // The count is tested before it is decremented, so a value of one means
  // the word that is finishing now is the final one.
  assign last_word = (remain_reg == (ADDR_W + 1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    dma_sel    = 1'b0;
    dma_we     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    take_start = 1'b0;
    byte_in    = 1'b0;
    byte_out   = 1'b0;
    capture    = 1'b0;
    word_step  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          take_start = 1'b1;
          if (word_cnt == '0) begin
            state_next = S_DONE;
          end else if (mode) begin
            state_next = S_RD_ISSUE;
          end else begin
            state_next = S_LD_BYTE;
          end
        end
      end
      S_LD_BYTE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          byte_in = 1'b1;
          if (last_byte) begin
            state_next = S_LD_WR;
          end
        end
      end
      S_LD_WR: begin
        // Hold the write back while the controller owns the port.
        if (!ctrl_sel) begin
          dma_sel    = 1'b1;
          dma_we     = 1'b1;
          word_step  = 1'b1;
          state_next = last_word ? S_DONE : S_LD_BYTE;
        end
      end
      S_RD_ISSUE: begin
        if (!ctrl_sel) begin
          dma_sel    = 1'b1;
          state_next = S_RD_CAP;
        end
      end
      S_RD_CAP: begin
        capture    = 1'b1;
        state_next = S_TX;
      end
      S_TX: begin
        out_valid = 1'b1;
        if (out_ready) begin
          byte_out = 1'b1;
          if (last_byte) begin
            word_step  = 1'b1;
            state_next = last_word ? S_DONE : S_RD_ISSUE;
          end
        end
      end
      S_DONE: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      remain_reg   <= '0;
      word_reg     <= '0;
      byte_cnt_reg <= '0;
      checksum_reg <= '0;
    end else begin
      if (take_start) begin
        addr_reg     <= base_addr;
        remain_reg   <= word_cnt;
        byte_cnt_reg <= '0;
        checksum_reg <= '0;
      end
      if (byte_in) begin
        word_reg     <= (word_reg << 8) | DATA_W'(in_data);
        checksum_reg <= checksum_reg + in_data;
        byte_cnt_reg <= last_byte ? '0 : byte_cnt_reg + BC_W'(1);
      end
      if (capture) begin
        word_reg     <= dma_rdata;
        byte_cnt_reg <= '0;
      end
      if (byte_out) begin
        word_reg     <= word_reg << 8;
        checksum_reg <= checksum_reg + word_reg[DATA_W-1 -: 8];
        byte_cnt_reg <= last_byte ? '0 : byte_cnt_reg + BC_W'(1);
      end
      if (word_step) begin
        // The address wraps naturally at the top of memory.
        addr_reg   <= addr_reg + ADDR_W'(1);
        remain_reg <= remain_reg - (ADDR_W + 1)'(1);
      end
    end
  end

  assign dma_addr  = addr_reg;
  assign dma_wdata = word_reg;
  assign out_data  = (state_reg == S_TX) ? word_reg[DATA_W-1 -: 8] : 8'h00;
  assign checksum  = checksum_reg;

endmodule

// File: tb/tb_xprog_loader.sv
// Self-checking bench for xprog_loader: a behavioural memory, a reference
// image of memory contents, and expected write/read/byte queues built from
// the transfer rules.
module tb_xprog_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int BYTES  = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_cnt;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              ctrl_sel;
  logic              dma_sel;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              busy;
  logic              done;
  logic [7:0]        checksum;

  xprog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .base_addr(base_addr), .word_cnt(word_cnt),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_sel(ctrl_sel), .dma_sel(dma_sel), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
    .busy(busy), .done(done), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural program memory with one-cycle read latency.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (dma_sel && dma_we) mem[dma_addr] <= dma_wdata;
    if (dma_sel && !dma_we) dma_rdata <= mem[dma_addr];
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                exp_wr_addr[$];
  logic [DATA_W-1:0] exp_wr_data[$];
  int                exp_rd_addr[$];
  logic [7:0]        exp_out[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled 2 time units after the falling edge, when inputs
  // driven at the falling edge have settled.
  logic       prev_we, prev_stall;
  logic [7:0] prev_data;
  initial begin
    prev_we = 0; prev_stall = 0; prev_data = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_we = 0; prev_stall = 0;
      end else begin
        if (dma_sel) check("sel_vs_ctrl", ctrl_sel, 0);
        if (dma_sel && dma_we) begin
          check("we_single_cycle", prev_we, 0);
          if (exp_wr_addr.size() == 0) check("wr_unexpected", 1, 0);
          else begin
            check("wr_addr", dma_addr, exp_wr_addr.pop_front());
            check("wr_data", dma_wdata, exp_wr_data.pop_front());
          end
        end
        if (dma_sel && !dma_we) begin
          if (exp_rd_addr.size() == 0) check("rd_unexpected", 1, 0);
          else check("rd_addr", dma_addr, exp_rd_addr.pop_front());
        end
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) check("out_unexpected", 1, 0);
          else check("out_byte", out_data, exp_out.pop_front());
        end
        prev_we    = dma_sel && dma_we;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_dma_sel", dma_sel, 0);
    check("rst_dma_we", dma_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dma_addr", dma_addr, 0);
    check("rst_dma_wdata", dma_wdata, 0);
    check("rst_out_data", out_data, 0);
    check("rst_checksum", checksum, 0);
  endtask

  // All tasks are entered and left just after a falling edge.
  task automatic pulse_start(input bit m, input int base, input int cnt);
    start = 1; mode = m; base_addr = ADDR_W'(base); word_cnt = (ADDR_W + 1)'(cnt);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input logic [7:0] exp_sum, input bit rnd);
    int g = 0;
    while (!done && g < 200) begin
      in_valid = 0; out_ready = 0;
      ctrl_sel = rnd && ($urandom_range(3) == 0);
      @(negedge clk);
      g++;
    end
    ctrl_sel = 0;
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    check("checksum", checksum, exp_sum);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("checksum_hold", checksum, exp_sum);
  endtask

  // Hold ctrl_sel high for 5 cycles while an access is pending, then release
  // and expect the access in that very cycle.
  task automatic stall_access(input bit we, input int a);
    for (int i = 0; i < 5; i++) begin
      ctrl_sel = 1; #1;
      check("stall_no_sel", dma_sel, 0);
      @(negedge clk);
    end
    ctrl_sel = 0; #1;
    check("stall_release_sel", dma_sel, 1);
    check("stall_release_we", dma_we, we);
    check("stall_release_addr", dma_addr, a);
    @(negedge clk);
  endtask

  task automatic run_load(input int base, input int cnt, input logic [7:0] bytes[$],
                          input bit stall, input bit rnd);
    logic [DATA_W-1:0] w;
    logic [7:0] sum = 0;
    int idx = 0;
    int g = 0;
    bit acc;
    int n = cnt * BYTES;
    for (int k = 0; k < cnt; k++) begin
      w = 0;
      for (int b = 0; b < BYTES; b++) w = (w << 8) | DATA_W'(bytes[k*BYTES+b]);
      exp_wr_addr.push_back((base + k) % DEPTH);
      exp_wr_data.push_back(w);
      ref_mem[(base + k) % DEPTH] = w;
    end
    for (int k = 0; k < n; k++) sum += bytes[k];
    pulse_start(0, base, cnt);
    while (idx < n && g < 5000) begin
      in_data  = bytes[idx];
      in_valid = rnd ? 1'($urandom_range(1)) : 1'b1;
      ctrl_sel = rnd && ($urandom_range(3) == 0);
      // A start pulse while busy must be ignored.
      start = rnd && (idx == 1);
      mode = 1; word_cnt = 1; base_addr = ADDR_W'($urandom_range(DEPTH - 1));
      #1;
      acc = in_valid && in_ready;
      @(negedge clk);
      g++;
      start = 0;
      if (acc) begin
        idx++;
        if (stall && (idx % BYTES == 0)) begin
          in_valid = 0;
          stall_access(1, (base + idx / BYTES - 1) % DEPTH);
        end
      end
    end
    in_valid = 0;
    if (g >= 5000) check("load_timeout", 0, 1);
    wait_done(sum, rnd);
  endtask

  task automatic run_dump(input int base, input int cnt, input int rpol,
                          input bit stall, input bit rnd);
    logic [7:0] sum = 0;
    logic [DATA_W-1:0] w;
    int got = 0;
    int g = 0;
    bit tog = 0;
    int n = cnt * BYTES;
    for (int k = 0; k < cnt; k++) begin
      exp_rd_addr.push_back((base + k) % DEPTH);
      w = ref_mem[(base + k) % DEPTH];
      for (int b = 0; b < BYTES; b++) begin
        exp_out.push_back(w[DATA_W-1-8*b -: 8]);
        sum += w[DATA_W-1-8*b -: 8];
      end
    end
    pulse_start(1, base, cnt);
    if (stall && cnt > 0) stall_access(0, base % DEPTH);
    while (got < n && g < 5000) begin
      out_ready = (rpol == 0) ? 1'b1 : (rpol == 1) ? tog : 1'($urandom_range(1));
      tog = ~tog;
      ctrl_sel = rnd && ($urandom_range(3) == 0);
      #1;
      if (out_valid && out_ready) got++;
      @(negedge clk);
      g++;
    end
    out_ready = 0;
    if (g >= 5000) check("dump_timeout", 0, 1);
    wait_done(sum, rnd);
  endtask

  initial begin
    logic [7:0] q[$];
    int base, cnt;
    rst_n = 0; start = 0; mode = 0; base_addr = 0; word_cnt = 0;
    in_data = 0; in_valid = 0; out_ready = 0; ctrl_sel = 0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1;
    @(negedge clk);

    // Directed load of two words, then dump with toggling ready.
    q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(12'h010, 2, q, 0, 0);
    check("mem_010", mem[10'h010], 32'h12345678);
    check("mem_011", mem[10'h011], 32'h9ABCDEF0);
    $display("load base=010 cnt=2 checksum=%0h", checksum);
    run_dump(12'h010, 2, 1, 0, 0);
    $display("dump base=010 cnt=2 checksum=%0h", checksum);

    // Controller contention on write and on read.
    q = {};
    for (int i = 0; i < 2 * BYTES; i++) q.push_back(8'($urandom_range(255)));
    run_load(12'h020, 2, q, 1, 0);
    $display("stalled load base=020 cnt=2");
    run_dump(12'h020, 2, 0, 1, 0);
    $display("stalled dump base=020 cnt=2");

    // Address wrap at the top of memory.
    q = {};
    for (int i = 0; i < 2 * BYTES; i++) q.push_back(8'($urandom_range(255)));
    run_load(12'h3FF, 2, q, 0, 0);
    check("wrap_mem_3ff", mem[10'h3FF], ref_mem[10'h3FF]);
    check("wrap_mem_000", mem[10'h000], ref_mem[10'h000]);
    $display("wrap load base=3FF cnt=2");
    run_dump(12'h3FF, 2, 2, 0, 0);
    $display("wrap dump base=3FF cnt=2");

    // Zero-length transfers in both modes.
    for (int m = 0; m < 2; m++) begin
      pulse_start(1'(m), 12'h055, 0);
      check("zero_done", done, 1);
      check("zero_checksum", checksum, 0);
      check("zero_no_sel", dma_sel, 0);
      @(negedge clk);
      check("zero_done_pulse", done, 0);
      $display("zero-length mode=%0d", m);
    end

    // Reset after three bytes of a load: nothing may be written.
    pulse_start(0, 12'h100, 2);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 8'(8'hA0 + i);
      @(negedge clk);
    end
    in_valid = 0;
    rst_n = 0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1;
    @(negedge clk);
    $display("reset mid-load");
    q = {};
    for (int i = 0; i < 2 * BYTES; i++) q.push_back(8'($urandom_range(255)));
    run_load(12'h100, 2, q, 0, 0);
    check("post_rst_mem_100", mem[10'h100], ref_mem[10'h100]);
    $display("load after reset base=100 cnt=2");

    // Randomised load/dump pairs with random handshakes and contention.
    for (int it = 0; it < 8; it++) begin
      base = $urandom_range(DEPTH - 1);
      cnt  = $urandom_range(4, 1);
      q = {};
      for (int i = 0; i < cnt * BYTES; i++) q.push_back(8'($urandom_range(255)));
      run_load(base, cnt, q, 0, 1);
      run_dump(base, cnt, 2, 0, 1);
      $display("random pair %0d base=%0h cnt=%0d checksum=%0h", it, base, cnt, checksum);
    end

    check("wr_queue_drained", exp_wr_addr.size(), 0);
    check("rd_queue_drained", exp_rd_addr.size(), 0);
    check("out_queue_drained", exp_out.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
